ysyx_25020037_idu_q: RTL
========================

# ysyx_25020037_idu_q

Queued, parametrised RV32I+Zicsr decode stage sitting between the IFU and EXU of the ysyx_25020037 core. Accepts fetched {pc, inst} pairs into a DEPTH-entry FIFO, decodes the head entry and holds the decoded bundle in an output register under a valid/ready handshake. It supports back-to-back throughput of one instruction per cycle, a synchronous pipeline flush and explicit illegal-instruction reporting.

## Interface
- DEPTH, 2, FIFO entries; power of two, at least 2.
- PC_W, 32, PC width.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of the queue and output register.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  queue can accept a bundle.
- in_pc  in  PC_W  fetch PC.
- in_inst  in  32  instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EXU accepts the bundle.
- out_pc  out  PC_W  PC of the decoded instruction.
- out_rd, out_rs1, out_rs2  out  5 each  register indices: inst[11:7], inst[19:15], inst[24:20].
- out_imm  out  32  selected immediate: I/S/B/U/J; 0 for R-type and SYSTEM without immediate.
- out_alu_op  out  17  one-hot ALU op. Bits 0 to 10: add, sub, slt, sltu, and, or, xor, sll, srl, sra, lui. Bits 11 to 16: bne, beq, bge, bgeu, blt, bltu.
- out_src1_is_pc, out_src2_is_imm  out  1 each  operand selects.
- out_gpr_we  out  1  register writeback enable; forced 0 when rd==0.
- out_load, out_store  out  1 each  memory op class.
- out_mem_size  out  2  memory access size: 0 byte, 1 half, 2 word.
- out_load_unsigned  out  1  asserted for lbu/lhu.
- out_branch, out_jump  out  1 each  branch class / jal or jalr.
- out_csr_op  out  2  CSR operation: 01 csrrw, 10 csrrs, 00 none.
- out_csr_addr  out  12  CSR address, inst[31:20].
- out_ecall, out_mret, out_ebreak, out_illegal  out  1 each  SYSTEM and exception flags.
- occupancy  out  $clog2(DEPTH+1)  number of valid FIFO entries.

## Operation
- **FIFO write.** The FIFO stores raw {pc, inst}. A push occurs when in_valid & in_ready. in_ready = (occupancy < DEPTH) & ~flush. in_ready has no combinational path from out_ready.
- **FIFO pop and load.** The output register loads the decode of the FIFO head when the FIFO is non-empty and (~out_valid | out_ready). Loading pops the FIFO in the same edge.
  - If the output is consumed and the FIFO is empty, out_valid falls.
  - A simultaneous push and pop leaves occupancy unchanged.
  - Read and write pointers wrap modulo DEPTH.
- **Decode coverage.** The decoder supports:
  - lui, auipc, jal, jalr, all six branches;
  - lb, lh, lw, lbu, lhu, sb, sh, sw;
  - all OP-IMM instructions, including slli/srli/srai (funct7 checked) and slti;
  - all OP instructions, with funct7 checked (0x00, or 0x20 for sub/sra);
  - csrrw, csrrs, ecall, ebreak, mret (exact 32-bit encodings).
- **Bubble and illegal encodings.**
  - inst 0x00000000 is a bubble: every flag is 0, including out_illegal.
  - Any other undecoded encoding sets out_illegal=1 and clears gpr_we, load, store, branch, jump, csr_op and alu_op.
- **Operand selects.** src1_is_pc for auipc, jal and branches. src2_is_imm for I-type, S, U, jal and branches.
- **ALU op for address and link.** alu_op[0] (add) for loads, stores, auipc, jal and jalr.
- **Flush.** Clears the FIFO (pointers and occupancy to 0) and out_valid in one edge. Flush has priority over push, pop and load.

## Timing
- **Reset.** in_ready=1, out_valid=0, occupancy=0, all out_* fields 0.
- **Latency.** A bundle pushed at edge E0 into an empty stage with an idle output appears with out_valid=1 after edge E1.
- **Throughput.** Sustained rate is 1 instruction/cycle when out_ready is held high.
- **Stall hold.** While out_valid & ~out_ready, all out_* fields are stable.
- **Back-pressure.** When occupancy==DEPTH, in_ready=0 even if out_ready=1 in the same cycle; the freed slot is visible the next cycle.
- **Reset mid-operation.** Queued and held instructions are discarded immediately and asynchronously.

## Test plan
- **Single instruction.** Reset, then push pc=0x80000000, inst=0x00500093 (addi x1,x0,5) with out_ready=1 → after 2 edges: out_valid=1, out_imm=5, rd=1, alu_op[0]=1, src2_is_imm=1, gpr_we=1, illegal=0.
- **Fill and stall.** DEPTH=4, out_ready=0, push 6 instructions → 1 held in the output register, 4 queued, occupancy=4, in_ready=0. Then set out_ready=1 → 5 outputs in push order on consecutive cycles.
- **Decode sweep.**
  - inst 0xFE000EE3 (beq x0,x0,-4) → alu_op[12]=1, imm=0xFFFFFFFC, src1_is_pc=1, branch=1.
  - inst 0x00004083 (lbu) → load=1, mem_size=0, load_unsigned=1.
- **SYSTEM and illegal encodings.**
  - inst 0x30200073 → mret=1.
  - inst 0x34129073 (csrrw x0,mepc,x5) → csr_op=01, csr_addr=0x341, gpr_we=0.
  - inst 0x0000000F (fence) → illegal=1.
  - inst 0x00000000 → all flags 0.
- **Flush with simultaneous push.** With 3 entries queued and out_valid=1, assert flush together with in_valid → next cycle out_valid=0, occupancy=0; the pushed bundle is dropped.
- **Asynchronous reset mid-stream.** Pulse rst between clock edges while traffic flows → outputs return to their reset values before the next edge.

Source files
------------

// File: rtl/ysyx_25020037_idu_q.sv
// Queued RV32I+Zicsr decode stage: buffers fetched {pc, inst} pairs in a FIFO
// and presents the decoded head instruction in a valid/ready output register.
module ysyx_25020037_idu_q #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [31:0]                in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [31:0]                out_imm,
  output logic [16:0]                out_alu_op,
  output logic                       out_src1_is_pc,
  output logic                       out_src2_is_imm,
  output logic                       out_gpr_we,
  output logic                       out_load,
  output logic                       out_store,
  output logic [1:0]                 out_mem_size,
  output logic                       out_load_unsigned,
  output logic                       out_branch,
  output logic                       out_jump,
  output logic [1:0]                 out_csr_op,
  output logic [11:0]                out_csr_addr,
  output logic                       out_ecall,
  output logic                       out_mret,
  output logic                       out_ebreak,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_AND  = 4;
  localparam int unsigned ALU_OR   = 5;
  localparam int unsigned ALU_XOR  = 6;
  localparam int unsigned ALU_SLL  = 7;
  localparam int unsigned ALU_SRL  = 8;
  localparam int unsigned ALU_SRA  = 9;
  localparam int unsigned ALU_LUI  = 10;
  localparam int unsigned ALU_BNE  = 11;
  localparam int unsigned ALU_BEQ  = 12;
  localparam int unsigned ALU_BGE  = 13;
  localparam int unsigned ALU_BGEU = 14;
  localparam int unsigned ALU_BLT  = 15;
  localparam int unsigned ALU_BLTU = 16;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [16:0]     alu_op;
    logic            src1_is_pc;
    logic            src2_is_imm;
    logic            gpr_we;
    logic            load;
    logic            store;
    logic [1:0]      mem_size;
    logic            load_unsigned;
    logic            branch;
    logic            jump;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic            ecall;
    logic            mret;
    logic            ebreak;
    logic            illegal;
  } dec_t;

  logic [PC_W-1:0]  fifo_pc   [DEPTH];
  logic [31:0]      fifo_inst [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  dec_t             dec;
  dec_t             q;

  assign in_ready = (occupancy < OCC_W'(DEPTH)) & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = (occupancy != '0) & (~out_valid | out_ready);

  // Raw storage needs no reset: only entries below occupancy are ever read out.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= in_pc;
      fifo_inst[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      occupancy <= occupancy + OCC_W'(1);
      else if (!push && pop) occupancy <= occupancy - OCC_W'(1);
    end
  end

  logic [31:0] inst;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal;

  assign inst  = fifo_inst[rd_ptr];
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Decode of the FIFO head; unrecognised encodings collapse to an illegal bundle.
  always_comb begin
    dec          = '0;
    legal        = 1'b1;
    dec.pc       = fifo_pc[rd_ptr];
    dec.rd       = inst[11:7];
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.csr_addr = inst[31:20];
    case (opc)
      OPC_LUI: begin
        dec.imm = imm_u; dec.alu_op[ALU_LUI] = 1'b1;
        dec.src2_is_imm = 1'b1; dec.gpr_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u; dec.alu_op[ALU_ADD] = 1'b1;
        dec.src1_is_pc = 1'b1; dec.src2_is_imm = 1'b1; dec.gpr_we = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = imm_j; dec.alu_op[ALU_ADD] = 1'b1; dec.jump = 1'b1;
        dec.src1_is_pc = 1'b1; dec.src2_is_imm = 1'b1; dec.gpr_we = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = imm_i; dec.alu_op[ALU_ADD] = 1'b1; dec.jump = 1'b1;
        dec.src2_is_imm = 1'b1; dec.gpr_we = 1'b1;
        legal = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        dec.imm = imm_b; dec.branch = 1'b1;
        dec.src1_is_pc = 1'b1; dec.src2_is_imm = 1'b1;
        case (f3)
          3'b000:  dec.alu_op[ALU_BEQ]  = 1'b1;
          3'b001:  dec.alu_op[ALU_BNE]  = 1'b1;
          3'b100:  dec.alu_op[ALU_BLT]  = 1'b1;
          3'b101:  dec.alu_op[ALU_BGE]  = 1'b1;
          3'b110:  dec.alu_op[ALU_BLTU] = 1'b1;
          3'b111:  dec.alu_op[ALU_BGEU] = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec.imm = imm_i; dec.alu_op[ALU_ADD] = 1'b1; dec.load = 1'b1;
        dec.src2_is_imm = 1'b1; dec.gpr_we = 1'b1;
        dec.mem_size = f3[1:0]; dec.load_unsigned = f3[2];
        legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OPC_STORE: begin
        dec.imm = imm_s; dec.alu_op[ALU_ADD] = 1'b1; dec.store = 1'b1;
        dec.src2_is_imm = 1'b1; dec.mem_size = f3[1:0];
        legal = f3 inside {3'b000, 3'b001, 3'b010};
      end
      OPC_OP_IMM: begin
        dec.imm = imm_i; dec.src2_is_imm = 1'b1; dec.gpr_we = 1'b1;
        case (f3)
          3'b000: dec.alu_op[ALU_ADD]  = 1'b1;
          3'b010: dec.alu_op[ALU_SLT]  = 1'b1;
          3'b011: dec.alu_op[ALU_SLTU] = 1'b1;
          3'b100: dec.alu_op[ALU_XOR]  = 1'b1;
          3'b110: dec.alu_op[ALU_OR]   = 1'b1;
          3'b111: dec.alu_op[ALU_AND]  = 1'b1;
          3'b001: if (f7 == 7'h00) dec.alu_op[ALU_SLL] = 1'b1; else legal = 1'b0;
          3'b101: begin
            if (f7 == 7'h00)      dec.alu_op[ALU_SRL] = 1'b1;
            else if (f7 == 7'h20) dec.alu_op[ALU_SRA] = 1'b1;
            else                  legal = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        dec.gpr_we = 1'b1;
        if (f7 == 7'h00) begin
          case (f3)
            3'b000: dec.alu_op[ALU_ADD]  = 1'b1;
            3'b001: dec.alu_op[ALU_SLL]  = 1'b1;
            3'b010: dec.alu_op[ALU_SLT]  = 1'b1;
            3'b011: dec.alu_op[ALU_SLTU] = 1'b1;
            3'b100: dec.alu_op[ALU_XOR]  = 1'b1;
            3'b101: dec.alu_op[ALU_SRL]  = 1'b1;
            3'b110: dec.alu_op[ALU_OR]   = 1'b1;
            3'b111: dec.alu_op[ALU_AND]  = 1'b1;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'b000) dec.alu_op[ALU_SUB] = 1'b1;
        else if (f7 == 7'h20 && f3 == 3'b101)     dec.alu_op[ALU_SRA] = 1'b1;
        else                                      legal = 1'b0;
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b001)              begin dec.csr_op = 2'b01; dec.gpr_we = 1'b1; end
        else if (f3 == 3'b010)         begin dec.csr_op = 2'b10; dec.gpr_we = 1'b1; end
        else if (inst == 32'h00000073) dec.ecall  = 1'b1;
        else if (inst == 32'h00100073) dec.ebreak = 1'b1;
        else if (inst == 32'h30200073) dec.mret   = 1'b1;
        else                           legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.imm           = '0;
      dec.alu_op        = '0;
      dec.src1_is_pc    = 1'b0;
      dec.src2_is_imm   = 1'b0;
      dec.gpr_we        = 1'b0;
      dec.load          = 1'b0;
      dec.store         = 1'b0;
      dec.mem_size      = '0;
      dec.load_unsigned = 1'b0;
      dec.branch        = 1'b0;
      dec.jump          = 1'b0;
      dec.csr_op        = '0;
      // The all-zero word is a pipeline bubble, not an exception.
      dec.illegal       = (inst != 32'h0);
    end
    if (dec.rd == 5'd0) dec.gpr_we = 1'b0;
  end

  // Output register: fields change only on a load, so they hold during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      q         <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_pc            = q.pc;
  assign out_rd            = q.rd;
  assign out_rs1           = q.rs1;
  assign out_rs2           = q.rs2;
  assign out_imm           = q.imm;
  assign out_alu_op        = q.alu_op;
  assign out_src1_is_pc    = q.src1_is_pc;
  assign out_src2_is_imm   = q.src2_is_imm;
  assign out_gpr_we        = q.gpr_we;
  assign out_load          = q.load;
  assign out_store         = q.store;
  assign out_mem_size      = q.mem_size;
  assign out_load_unsigned = q.load_unsigned;
  assign out_branch        = q.branch;
  assign out_jump          = q.jump;
  assign out_csr_op        = q.csr_op;
  assign out_csr_addr      = q.csr_addr;
  assign out_ecall         = q.ecall;
  assign out_mret          = q.mret;
  assign out_ebreak        = q.ebreak;
  assign out_illegal       = q.illegal;

endmodule
